// File: rtl/vec_seq_pkg.sv
// Shared types and sizing for the exhaustive 4-input vector sequencer.
package vec_seq_pkg;

  localparam int NUM_VECTORS = 16;
  localparam int IDX_W       = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    CAPTURE,
    DONE
  } state_t;

endpackage

// File: rtl/vec_sequencer_hold_timer.sv
// 8-bit down-counter timing how long each vector stays in APPLY.
module hold_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic       tick,
  output logic       expire
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_value;
    end else if (tick && (count != 8'd0)) begin
      count <= count - 8'd1;
    end
  end

  assign expire = (count == 8'd0);

endmodule

// File: rtl/vec_sequencer.sv
// Walks {a,b,c,d} through all 16 vectors, capturing f for each into resp.
// Optional f==1 tally on ones_count when VEC_SEQ_ONES_COUNT_EN is defined.
module vec_sequencer
  import vec_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        f,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        e,
  output logic        busy,
  output logic        done,
  output logic [15:0] resp,
  output logic [4:0]  ones_count
);

  // APPLY spans HOLD_CYCLES-1 cycles, so the timer expires after HOLD_CYCLES-2 decrements.
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 2);

  state_t           state, next_state;
  logic [IDX_W-1:0] idx, idx_next;
  logic             expire, accept, capture, load_timer, run_next;

  hold_timer u_hold_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load_timer),
    .load_value (HOLD_LOAD),
    .tick       (state == APPLY),
    .expire     (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Abort takes priority over capture, so an aborted vector is never recorded.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    capture    = 1'b0;
    load_timer = 1'b0;
    idx_next   = idx;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          load_timer = 1'b1;
          idx_next   = '0;
          next_state = APPLY;
        end
      end
      APPLY: begin
        if (abort) begin
          next_state = IDLE;
        end else if (expire) begin
          next_state = CAPTURE;
        end
      end
      CAPTURE: begin
        if (abort) begin
          next_state = IDLE;
        end else begin
          capture = 1'b1;
          if (idx == LAST_IDX) begin
            next_state = DONE;
          end else begin
            idx_next   = IDX_W'(idx + 1);
            load_timer = 1'b1;
            next_state = APPLY;
          end
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    run_next = (next_state == APPLY) || (next_state == CAPTURE);
  end

  // Outputs are registered from the next-state decode so they line up with the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= '0;
      resp         <= 16'd0;
      {a, b, c, d} <= 4'd0;
      e            <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      idx <= idx_next;
      if (accept) begin
        resp <= 16'd0;
      end else if (capture) begin
        resp[idx] <= f;
      end
      {a, b, c, d} <= run_next ? idx_next : 4'd0;
      e            <= run_next;
      busy         <= run_next;
      done         <= (next_state == DONE);
    end
  end

`ifdef VEC_SEQ_ONES_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_count <= 5'd0;
    end else if (accept) begin
      ones_count <= 5'd0;
    end else if (capture && f && (ones_count != 5'd16)) begin
      ones_count <= ones_count + 5'd1;
    end
  end
`else
  assign ones_count = 5'd0;
`endif

endmodule

// File: tb/tb_vec_sequencer.sv
// Scoreboard bench for vec_sequencer: HOLD_CYCLES=4 and HOLD_CYCLES=2 instances side by side.
module tb_vec_sequencer;

`ifdef VEC_SEQ_ONES_COUNT_EN
  localparam bit ONES_EN = 1'b1;
`else
  localparam bit ONES_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] resp;
    logic [4:0]  ones;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start4 = 1'b0, abort4 = 1'b0, start2 = 1'b0, abort2 = 1'b0;
  logic mode4 = 1'b0;
  logic [15:0] pat2 = 16'hA5C3;
  logic a4, b4, c4, d4, e4, busy4, done4;
  logic a2, b2, c2, d2, e2, busy2, done2;
  logic [15:0] resp4, resp2;
  logic [4:0] ones4, ones2;
  logic f4, f2;

  int checks = 0;
  int errors = 0;
  exp_t q4[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  assign f4 = mode4 ? (a4 ^ b4 ^ c4 ^ d4) : 1'b1;
  assign f2 = pat2[{a2, b2, c2, d2}];

  vec_sequencer #(.HOLD_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .f(f4),
    .a(a4), .b(b4), .c(c4), .d(d4), .e(e4), .busy(busy4), .done(done4),
    .resp(resp4), .ones_count(ones4)
  );

  vec_sequencer #(.HOLD_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .f(f2),
    .a(a2), .b(b2), .c(c2), .d(d2), .e(e2), .busy(busy2), .done(done2),
    .resp(resp2), .ones_count(ones2)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  // Pulses start for one cycle on the HOLD_CYCLES=4 instance and records the expected run.
  task automatic applyStimulus(input logic [15:0] resp, input logic [4:0] ones, input bit with_abort);
    exp_t x;
    x.resp = resp;
    x.ones = ONES_EN ? ones : 5'd0;
    x.lat  = 65;
    q4.push_back(x);
    @(negedge clk);
    start4 = 1'b1;
    abort4 = with_abort;
    @(negedge clk);
    start4 = 1'b0;
    abort4 = 1'b0;
  endtask

  task automatic waitDrained(input string name);
    int n = 0;
    while ((q4.size() != 0 || q2.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_timeout"}, 32'(q4.size() + q2.size()), 32'd0);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_out4"}, {a4, b4, c4, d4, e4, busy4, done4, resp4, ones4}, 32'd0);
    checkOutput({name, "_out2"}, {a2, b2, c2, d2, e2, busy2, done2, resp2, ones2}, 32'd0);
  endtask

  // Monitor for the HOLD_CYCLES=4 instance: vector stepping plus scoreboard on done.
  int  cyc4 = 0;
  logic prev4 = 1'b0;
  always @(negedge clk) begin
    exp_t x;
    if (busy4 && !prev4) cyc4 = 1;
    else cyc4++;
    prev4 = busy4;
    if (busy4) begin
      checkOutput("vec4", {28'd0, a4, b4, c4, d4}, 32'((cyc4 - 1) / 4));
      checkOutput("e4", {31'd0, e4}, 32'd1);
    end else begin
      checkOutput("idle_vec4", {27'd0, a4, b4, c4, d4, e4}, 32'd0);
    end
    if (done4) begin
      if (q4.size() == 0) begin
        checkOutput("unexpected_done4", 32'd1, 32'd0);
      end else begin
        x = q4.pop_front();
        checkOutput("resp4", {16'd0, resp4}, {16'd0, x.resp});
        checkOutput("ones4", {27'd0, ones4}, {27'd0, x.ones});
        checkOutput("latency4", 32'(cyc4), 32'(x.lat));
      end
    end
  end

  // Monitor for the HOLD_CYCLES=2 instance.
  int  cyc2 = 0;
  logic prev2 = 1'b0;
  always @(negedge clk) begin
    exp_t x;
    if (busy2 && !prev2) cyc2 = 1;
    else cyc2++;
    prev2 = busy2;
    if (busy2) begin
      checkOutput("vec2", {28'd0, a2, b2, c2, d2}, 32'((cyc2 - 1) / 2));
      checkOutput("e2", {31'd0, e2}, 32'd1);
    end else begin
      checkOutput("idle_vec2", {27'd0, a2, b2, c2, d2, e2}, 32'd0);
    end
    if (done2) begin
      if (q2.size() == 0) begin
        checkOutput("unexpected_done2", 32'd1, 32'd0);
      end else begin
        x = q2.pop_front();
        checkOutput("resp2", {16'd0, resp2}, {16'd0, x.resp});
        checkOutput("ones2", {27'd0, ones2}, {27'd0, x.ones});
        checkOutput("latency2", 32'(cyc2), 32'(x.lat));
      end
    end
  end

  initial begin
    exp_t x;
    #2;
    checkAllZero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkAllZero("post_reset");

    // f tied high
    mode4 = 1'b0;
    applyStimulus(16'hFFFF, 5'd16, 1'b0);
    waitDrained("all_ones");

    // f = parity of the vector
    mode4 = 1'b1;
    applyStimulus(16'h6996, 5'd8, 1'b0);
    waitDrained("parity");

    // start re-asserted mid-run must not disturb the run
    mode4 = 1'b0;
    applyStimulus(16'hFFFF, 5'd16, 1'b0);
    repeat (28) @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    waitDrained("restart_ignored");

    // abort during vector 5 (cycle 22 of the run)
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (21) @(negedge clk);
    checkOutput("abort_vec", {28'd0, a4, b4, c4, d4}, 32'd5);
    abort4 = 1'b1;
    @(negedge clk);
    abort4 = 1'b0;
    checkOutput("abort_busy", {31'd0, busy4}, 32'd0);
    checkOutput("abort_resp", {16'd0, resp4}, 32'h001F);
    checkOutput("abort_ones", {27'd0, ones4}, ONES_EN ? 32'd5 : 32'd0);
    repeat (10) @(negedge clk);
    checkOutput("resp_held", {16'd0, resp4}, 32'h001F);

    // start and abort together in IDLE: start wins
    applyStimulus(16'hFFFF, 5'd16, 1'b1);
    waitDrained("start_abort");

    // reset mid-run clears everything and needs a fresh start
    mode4 = 1'b1;
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkAllZero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    checkOutput("no_autorestart", {31'd0, busy4}, 32'd0);

    // HOLD_CYCLES=2 with an arbitrary f pattern
    x.resp = 16'hA5C3;
    x.ones = ONES_EN ? 5'd8 : 5'd0;
    x.lat  = 33;
    q2.push_back(x);
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    waitDrained("hold2");

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
